// File: rtl/round_robin_mux.sv
// Registered N-to-1 multiplexer with fixed or round-robin channel
// selection and a one-word valid/ready output stage.
module round_robin_mux #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  localparam logic [SEL_W-1:0] PTR_RST =
    SEL_W'(CHANNELS - 1);

  logic             state;
  logic [SEL_W-1:0] ptr;
  logic             load_en;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] ci;
  logic [WIDTH-1:0] gnt_data;
  int               c;

  assign out_valid = state;
  assign load_en   = (state == EMPTY) || out_ready;

  // Downward scan so the nearest valid channel after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    c       = 0;
    ci      = '0;
    if (mode) begin
      for (int k = CHANNELS; k >= 1; k--) begin
        c = int'(ptr) + k;
        if (c >= CHANNELS) c = c - CHANNELS;
        ci = SEL_W'(c);
        if (in_valid[ci]) begin
          gnt_vld = 1'b1;
          gnt     = ci;
        end
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt == SEL_W'(i))
        gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_n && load_en && gnt_vld
                    && (gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_chan <= '0;
      ptr      <= PTR_RST;
    end else if (load_en) begin
      if (gnt_vld) begin
        state    <= FULL;
        out_data <= gnt_data;
        out_chan <= gnt;
        if (mode) ptr <= gnt;
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: doc/round_robin_mux.md
ROUND_ROBIN_MUX -- requirements
Module: round_robin_mux

Interface
REQ-001 Parameter WIDTH, default 64, data width per channel in bits; legal values 1..128.
REQ-002 Parameter CHANNELS, default 4, number of input channels; legal values 2..16.
REQ-003 Derived parameter SEL_W = max(1, clog2(CHANNELS)), width of channel indices.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel valid.
REQ-008 in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SEL_W  channel index used in mode 0; ignored in mode 1.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SEL_W  index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_chan hold a valid word.
REQ-014 out_ready  input  1  downstream accepts the word when high with out_valid.

Function
REQ-015 Output stage is a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en = EMPTY or (FULL and out_ready), evaluated combinationally each cycle.
REQ-017 Mode 0: grant = sel when in_valid[sel]=1; otherwise no grant; sel >= CHANNELS yields no grant.
REQ-018 Mode 1: grant = first channel with in_valid=1 searching ptr+1, ptr+2, ... modulo CHANNELS, ending at ptr itself; no valid channel yields no grant.
REQ-019 in_ready[g] = load_en for granted channel g; all other in_ready bits 0; in_ready is combinational.
REQ-020 Transfer in occurs when in_valid[g] and in_ready[g]; on that edge out_data <= channel g data, out_chan <= g, FSM -> FULL.
REQ-021 load_en with no grant: FULL -> EMPTY if out_ready, EMPTY stays EMPTY.
REQ-022 FULL and out_ready=0: out_data, out_chan, out_valid held unchanged; all in_ready 0.
REQ-023 Simultaneous output accept and input transfer in one cycle: FSM stays FULL with new word; sustained throughput one word per cycle.
REQ-024 Latency: input word appears on out_data exactly 1 cycle after its transfer edge.
REQ-025 ptr (SEL_W bits) updates to g only on a transfer in mode 1; unchanged in mode 0 and on cycles without transfer.
REQ-026 Mode or sel changes take effect on the next arbitration; a held FULL word is never altered by them; ptr retained across mode switches.
REQ-027 Wrap-around: ptr = CHANNELS-1 searches from channel 0; with CHANNELS not a power of two, indices >= CHANNELS are skipped.
REQ-028 No word is duplicated or dropped: every transfer in yields exactly one out_valid&&out_ready acceptance.

Reset
REQ-029 rst_n=0 asynchronously forces out_valid=0 (EMPTY), out_data=0, out_chan=0, ptr=CHANNELS-1, independent of clk.
REQ-030 While rst_n=0 all in_ready bits SHALL be 0.
REQ-031 Reset asserted mid-transfer discards the held word; first arbitration after release in mode 1 starts at channel 0.
REQ-032 Operation resumes on the first rising clk edge after rst_n deasserts.

Verification (WIDTH=64, CHANNELS=4)
REQ-033 Mode 0, sel=2, in_valid=4'b0100, ch2=64'hffffffffffffffff, out_ready=1 -> in_ready=4'b0100; next cycle out_data=64'hffffffffffffffff, out_chan=2, out_valid=1.
REQ-034 Mode 1 after reset, in_valid=4'b1111, ch i data=i, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with out_data equal to out_chan, one word per cycle.
REQ-035 Mode 1, in_valid=4'b1001, ptr=3 -> grant ch0; then ptr=0 -> grant ch3; wrap verified.
REQ-036 FULL with out_ready=0 for 5 cycles, all in_valid=1 -> out_data stable, in_ready=4'b0000 throughout; out_ready=1 -> next word loaded same edge.
REQ-037 Mode 0, sel=1, in_valid=4'b0001 -> no grant, out_valid falls to 0 after pending word accepted.
REQ-038 rst_n pulsed low between clk edges while FULL -> out_valid=0, out_data=0 immediately; after release mode 1 with in_valid=4'b1111 grants ch0 first.
